// File: rtl/cntr_pkg.sv
// Shared constants and helpers for the parameterised counter family.
package cntr_pkg;

  // Direction and mode encodings for the up / sat inputs
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // One extra bit so that MODULO = 2**32 is representable
  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned CALC_W    = MAX_WIDTH + 1;

  // Limit a value to the count range 0..modulo-1
  function automatic logic [CALC_W-1:0] clamp_mod(input logic [CALC_W-1:0] value,
                                                  input logic [CALC_W-1:0] modulo);
    return (value >= modulo) ? (modulo - CALC_W'(1)) : value;
  endfunction

endpackage

// File: rtl/cntr_next.sv
// Next-state logic for cntr_param: priority clr > ld > en > hold.
// Ports:
//   q_i        current count
//   d_i        load value (clamped to MODULO-1)
//   clr_i      synchronous clear to RST_VAL
//   ld_i       synchronous load
//   en_i       count enable
//   up_i       direction (1 = up)
//   sat_i      mode (1 = saturate, 0 = wrap)
//   q_nxt_o    next count
//   wrap_nxt_o next value of the wrap pulse register
//   at_lim_o   current count sits at the limit for the current direction
module cntr_next
  import cntr_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULO  = 16,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] q_nxt_o,
  output logic             wrap_nxt_o,
  output logic             at_lim_o
);

  localparam logic [CALC_W-1:0] MOD_C = CALC_W'(MODULO);
  localparam logic [WIDTH-1:0]  MAX_Q = WIDTH'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0]  RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] lim;

  // Limit follows the direction presented this cycle; no direction history
  assign lim      = (up_i == DIR_UP) ? MAX_Q : '0;
  assign at_lim_o = (q_i == lim);

  always_comb begin
    q_nxt_o    = q_i;
    wrap_nxt_o = 1'b0;
    if (clr_i) begin
      q_nxt_o = RST_Q;
    end else if (ld_i) begin
      q_nxt_o = WIDTH'(clamp_mod(CALC_W'(d_i), MOD_C));
    end else if (en_i) begin
      if (!at_lim_o) begin
        q_nxt_o = (up_i == DIR_UP) ? (q_i + WIDTH'(1)) : (q_i - WIDTH'(1));
      end else if (sat_i == MODE_WRAP) begin
        q_nxt_o    = (up_i == DIR_DN) ? MAX_Q : '0;
        wrap_nxt_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cntr_param.sv
// Parameterised loadable up/down counter with wrap/saturate modes,
// cascade terminal count and a registered wrap pulse.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (q=RST_VAL, wrap=0)
//   clr   synchronous clear to RST_VAL
//   ld/d  synchronous load (clamped to MODULO-1)
//   en    count enable
//   up    direction, 1 = increment
//   sat   1 = saturate at limits, 0 = wrap
//   q     registered count
//   tc    combinational terminal count for cascading into the next en
//   wrap  one-cycle registered pulse after a wrapping edge
module cntr_param
  import cntr_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULO  = 16,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  // Parameter legality, caught at elaboration
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("cntr_param: WIDTH must be 1..32");
  end
  if (MODULO < 64'd2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
    $error("cntr_param: MODULO must be 2..2**WIDTH");
  end
  if (clamp_mod(CALC_W'(RST_VAL), CALC_W'(MODULO)) != CALC_W'(RST_VAL) ||
      RST_VAL >= MODULO) begin : g_bad_rst_val
    $error("cntr_param: RST_VAL must be below MODULO");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_lim;

  cntr_next #(
    .WIDTH   (WIDTH),
    .MODULO  (MODULO),
    .RST_VAL (RST_VAL)
  ) u_next (
    .q_i        (q_q),
    .d_i        (d),
    .clr_i      (clr),
    .ld_i       (ld),
    .en_i       (en),
    .up_i       (up),
    .sat_i      (sat),
    .q_nxt_o    (q_d),
    .wrap_nxt_o (wrap_d),
    .at_lim_o   (at_lim)
  );

  // Count and wrap-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // High in the cycle before a wrapping edge so a downstream stage counts on that edge
  assign tc   = en & at_lim & (sat == MODE_WRAP) & ~clr & ~ld;
  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_cntr_param.sv
module tb_cntr_param;

  logic       clk = 1'b0;
  logic       rst, clr, ld, en, up, sat;
  logic [3:0] d;
  logic [3:0] q10, q16;
  logic       tc10, tc16, wrap10, wrap16;

  // cascade pair
  logic       c_rst, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int n_assert = 0;
  int n_fail   = 0;
  int m10, m16;            // reference counts

  always #5 clk = ~clk;

  cntr_param #(.WIDTH(4), .MODULO(10), .RST_VAL(0)) dut10 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .up(up), .sat(sat),
    .q(q10), .tc(tc10), .wrap(wrap10));

  cntr_param #(.WIDTH(4), .MODULO(16), .RST_VAL(3)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .up(up), .sat(sat),
    .q(q16), .tc(tc16), .wrap(wrap16));

  cntr_param #(.WIDTH(4), .MODULO(10), .RST_VAL(0)) u_lo (
    .clk(clk), .rst(c_rst), .clr(1'b0), .ld(1'b0), .d(4'd0), .en(c_en), .up(1'b1),
    .sat(1'b0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap));

  cntr_param #(.WIDTH(4), .MODULO(10), .RST_VAL(0)) u_hi (
    .clk(clk), .rst(c_rst), .clr(1'b0), .ld(1'b0), .d(4'd0), .en(lo_tc), .up(1'b1),
    .sat(1'b0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap));

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: modular arithmetic for wrap, min/max for saturate
  task automatic model(input int cur, input int mod, input int rv,
                       output int nxt, output int w, output int t);
    int di;
    di  = int'(d);
    w   = 0;
    nxt = cur;
    t   = (en && !clr && !ld && !sat && (up ? (cur == mod - 1) : (cur == 0))) ? 1 : 0;
    if (clr) nxt = rv;
    else if (ld) nxt = (di >= mod) ? mod - 1 : di;
    else if (en) begin
      if (up) begin
        if (sat) nxt = (cur + 1 > mod - 1) ? mod - 1 : cur + 1;
        else begin
          nxt = (cur + 1) % mod;
          w   = (nxt < cur) ? 1 : 0;
        end
      end else begin
        if (sat) nxt = (cur - 1 < 0) ? 0 : cur - 1;
        else begin
          nxt = (cur - 1 + mod) % mod;
          w   = (nxt > cur) ? 1 : 0;
        end
      end
    end
  endtask

  // One clock edge on the main pair: check tc before, q/wrap after
  task automatic step(input string tag);
    int n10, w10, t10, n16, w16, t16;
    #1;
    model(m10, 10, 0, n10, w10, t10);
    model(m16, 16, 3, n16, w16, t16);
    check({tag, ".tc10"}, int'(tc10), t10);
    check({tag, ".tc16"}, int'(tc16), t16);
    @(posedge clk);
    #1;
    m10 = n10;
    m16 = n16;
    check({tag, ".q10"}, int'(q10), m10);
    check({tag, ".wrap10"}, int'(wrap10), w10);
    check({tag, ".q16"}, int'(q16), m16);
    check({tag, ".wrap16"}, int'(wrap16), w16);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; d = '0;
    c_rst = 1'b1; c_en = 1'b0;
    m10 = 0; m16 = 3;
    repeat (2) @(posedge clk);
    #1;
    check("reset.q10", int'(q10), 0);
    check("reset.wrap10", int'(wrap10), 0);
    check("reset.q16", int'(q16), 3);
    check("reset.lo", int'(lo_q), 0);
    rst = 1'b0; c_rst = 1'b0;

    // count up to 7, then async reset mid-cycle
    en = 1'b1; up = 1'b1;
    repeat (7) step("up7");
    check("pre_rst.q10", int'(q10), 7);
    #2 rst = 1'b1;
    #1;
    check("async_rst.q10", int'(q10), 0);
    check("async_rst.wrap10", int'(wrap10), 0);
    check("async_rst.q16", int'(q16), 3);
    #1 rst = 1'b0;
    m10 = 0; m16 = 3;
    @(posedge clk);
    #1;
    m10 = 1; m16 = 4;
    check("post_rst.q10", int'(q10), 1);
    check("post_rst.q16", int'(q16), 4);

    // wrap up from 8
    ld = 1'b1; d = 4'd8;
    step("ld8");
    ld = 1'b0;
    repeat (3) step("wrap_up");
    check("wrap_up.final", int'(q10), 1);

    // wrap down from 1
    ld = 1'b1; d = 4'd1;
    step("ld1");
    ld = 1'b0; up = 1'b0;
    repeat (2) step("wrap_dn");
    check("wrap_dn.final", int'(q10), 9);

    // saturate at top, then step down
    up = 1'b1; sat = 1'b1;
    repeat (3) step("sat_up");
    check("sat_up.final", int'(q10), 9);
    up = 1'b0;
    step("sat_dn");
    check("sat_dn.final", int'(q10), 8);

    // load clamp and priorities
    sat = 1'b0; en = 1'b0; ld = 1'b1; d = 4'd12;
    step("ld_clamp");
    check("ld_clamp.final", int'(q10), 9);
    d = 4'd5; en = 1'b1; up = 1'b1;
    step("ld_wins");
    check("ld_wins.final", int'(q10), 5);
    clr = 1'b1;
    step("clr_wins");
    check("clr_wins.final", int'(q10), 0);
    clr = 1'b0; ld = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 19) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom_range(0, 1));
      sat = ($urandom_range(0, 4) == 0);
      d   = 4'($urandom_range(0, 15));
      step("rand");
    end
    clr = 1'b0; ld = 1'b0; en = 1'b0;

    // two-digit cascade 00..99 then 00
    c_en = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      @(posedge clk);
      #1;
      check("casc.value", int'(hi_q) * 10 + int'(lo_q), i);
      check("casc.lo_wrap", int'(lo_wrap), (i % 10 == 0) ? 1 : 0);
      check("casc.hi_wrap", int'(hi_wrap), 0);
    end
    check("casc.hi_tc_at99", int'(lo_tc & hi_tc), 1);
    @(posedge clk);
    #1;
    check("casc.roll_value", int'(hi_q) * 10 + int'(lo_q), 0);
    check("casc.roll_lo_wrap", int'(lo_wrap), 1);
    check("casc.roll_hi_wrap", int'(hi_wrap), 1);
    @(posedge clk);
    #1;
    check("casc.after_value", int'(hi_q) * 10 + int'(lo_q), 1);
    check("casc.after_wraps", int'(lo_wrap | hi_wrap), 0);
    c_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cntr_param.md
Name: cntr_param

Overview:
- Parametrised successor to the team's 4-bit loadable binary counter.
- Adds:
  - configurable width and modulo;
  - up/down counting and count enable;
  - synchronous clear;
  - wrap or saturate mode;
  - a cascade carry and a registered wrap pulse.
- Used as the general-purpose counter for timers, BCD digits (MODULO=10) and address generators.
- Counter chains are built by feeding one stage's tc into the next stage's en.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH; an illegal value triggers an elaboration error.
- RST_VAL, 0, value loaded by rst and clr; must be < MODULO.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- clr  in  1  synchronous clear to RST_VAL
- ld  in  1  synchronous load of d
- d  in  WIDTH  load value
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- sat  in  1  mode: 1 = saturate at limits, 0 = wrap
- q  out  WIDTH  current count, registered
- tc  out  1  terminal count, combinational, used for cascading
- wrap  out  1  one-cycle registered pulse on a wrap event

Behaviour:
- Reset:
  - rst high → q=RST_VAL and wrap=0 immediately, independent of clk.
  - Outputs hold while rst is high.
  - Deassertion is synchronised externally; the first active edge is the first clk edge with rst low.
- Priority on each rising clk edge (rst low): clr > ld > en > hold.
- clr: q←RST_VAL, wrap←0.
- ld:
  - d < MODULO → q←d.
  - d ≥ MODULO → q←MODULO-1 (clamp).
  - wrap←0 in both cases.
- Terminal value:
  - Up: limit = MODULO-1.
  - Down: limit = 0.
  - at_lim = (q == limit for the current up).
- en=1, at_lim=0: q←q+1 (up) or q−1 (down), modulo-free arithmetic in WIDTH bits; wrap←0.
- en=1, at_lim=1, sat=0: q←0 (up) or MODULO-1 (down); wrap←1 for exactly one cycle.
- en=1, at_lim=1, sat=1: q holds; wrap←0.
- en=0: q holds; wrap←0.
- tc = en & at_lim & ~sat & ~clr & ~ld (combinational). It is high in the cycle before a wrap edge, so the next cascaded stage counts on that same edge.
- Latency:
  - q reflects ld/clr/count one cycle after the edge.
  - wrap is asserted in the cycle following the wrapping edge, coincident with the wrapped q.
- Direction change:
  - up may change on any cycle.
  - at_lim is evaluated with the current up value.
  - No extra state is kept.
- MODULO = 2**WIDTH: natural binary roll-over; the behaviour is identical.
- WIDTH=1, MODULO=2: toggle counter; up is irrelevant to the value sequence, but at_lim still follows direction.
- q never holds a value ≥ MODULO: the clamp on load and the RST_VAL check guarantee this.
- rst asserted mid-count: q is forced to RST_VAL immediately; no wrap pulse is produced.

Decomposition:
- Package cntr_pkg holds:
  - constants DIR_UP=1, DIR_DN=0, MODE_WRAP=0, MODE_SAT=1;
  - function clamp_mod(value, MODULO), used by ld and by parameter checks.
- Sub-module cntr_next (combinational):
  - inputs: q, d, clr, ld, en, up, sat;
  - outputs: next q, next wrap, at_lim.
- cntr_param instantiates cntr_next plus the async-reset register bank and the tc logic. This mirrors the team's split of flip-flop and next-state logic.

Test Plan (WIDTH=4, MODULO=10, RST_VAL=0 unless stated):
- rst pulse mid-count at q=7, asynchronous to clk → q=0 within the same cycle, wrap=0. After release, en=1, up=1 → q=1 on the first edge.
- en=1, up=1, sat=0 from q=8 → tc=1 while q=9; sequence 9→0; wrap=1 for one cycle with q=0; the following cycle q=1 and wrap=0.
- up=0, sat=0 from q=1 → 1→0→9; wrap pulses once; tc=1 while q=0.
- sat=1, up=1 from q=9 for 3 cycles → q stays 9, tc=0, wrap=0. Then up=0 → 8.
- ld=1, d=12 → q=9 (clamp). ld=1, d=5, en=1 in the same cycle → q=5 (load wins). clr=1 with ld=1 → q=0.
- Two instances cascaded (upper en = lower tc), MODULO=10, count 99 cycles from 00 → 99; the 100th edge → 00 with both wrap outputs pulsing together.
